// File: rtl/fp_div_pkg.sv
// -----------------------------------------------------------------------------
// fp_div_pkg
// Shared constants for the single-precision divider datapath:
//   - IEEE-754 single field widths and exponent limits
//   - operand class codes carried alongside each quotient
//   - raw quotient / internal exponent widths used by the round stage
// -----------------------------------------------------------------------------
package fp_div_pkg;

    // Raw quotient: 1 integer bit + 25 fraction bits, value in [0.5, 2).
    localparam int QUO_W = 26;
    // Signed biased exponent, wide enough for expA - expB + 127 plus carries.
    localparam int EXP_W = 10;

    localparam int FRAC_W   = 23;
    localparam int SIG_W    = 24;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Operand class codes.
    localparam logic [1:0] CLS_NORM = 2'b00;
    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_NAN  = 2'b11;

endpackage

// File: rtl/fp_div_norm.sv
// -----------------------------------------------------------------------------
// fp_div_norm
// Combinational normalize step: picks the 24-bit significand from the raw
// quotient, derives guard/sticky and the round-to-nearest-even increment.
// Ports:
//   quo_i    raw quotient (bit QW-1 or QW-2 set for normal operands)
//   sticky_i divider remainder nonzero
//   exp_i    signed biased exponent before normalization
//   sig_o    24-bit significand (hidden bit included)
//   inc_o    round-up request for the significand
//   exp_o    exponent after normalization
// -----------------------------------------------------------------------------
module fp_div_norm
    import fp_div_pkg::*;
#(
    parameter int QW = QUO_W,
    parameter int EW = EXP_W
) (
    input  logic [QW-1:0]        quo_i,
    input  logic                 sticky_i,
    input  logic signed [EW-1:0] exp_i,
    output logic [SIG_W-1:0]     sig_o,
    output logic                 inc_o,
    output logic signed [EW-1:0] exp_o
);

    localparam logic signed [EW-1:0] ONE = EW'(1);

    logic guard;
    logic stick;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (that would infer a latch).
        // Quotient below 1.0: shift left by one, exponent drops by one.
        sig_o = quo_i[QW-2 -: SIG_W];
        guard = quo_i[QW-SIG_W-2];
        stick = sticky_i;
        exp_o = exp_i - ONE;

        if (quo_i[QW-1]) begin
            sig_o = quo_i[QW-1 -: SIG_W];
            guard = quo_i[QW-SIG_W-1];
            stick = (|quo_i[QW-SIG_W-2:0]) | sticky_i;
            exp_o = exp_i;
        end

        // Round to nearest, ties to even.
        inc_o = guard & (stick | sig_o[0]);
    end

endmodule

// File: rtl/fp_div_round.sv
// -----------------------------------------------------------------------------
// fp_div_round
// Post-divide normalize/round stage of the single-precision divider.
// Two-stage valid/ready pipeline: S1 registers the normalized significand
// and round decision, S2 rounds, applies exponent limits and packs the result.
// Ports:
//   clk, n_rst              clock, asynchronous active-low reset
//   in_valid / in_ready     input handshake
//   in_sign, in_exp         result sign, signed biased exponent
//   in_quo, in_sticky       raw quotient and remainder-nonzero flag
//   in_special              operand class (normal / zero / inf / NaN)
//   out_valid / out_ready   output handshake
//   result                  packed IEEE-754 single
//   overflow, underflow     saturate-to-inf / flush-to-zero flags
// -----------------------------------------------------------------------------
module fp_div_round
    import fp_div_pkg::*;
#(
    parameter int QW = QUO_W,
    parameter int EW = EXP_W
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [EW-1:0] in_exp,
    input  logic [QW-1:0]        in_quo,
    input  logic                 in_sticky,
    input  logic [1:0]           in_special,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          result,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic signed [EW-1:0] ONE   = EW'(1);
    localparam logic signed [EW-1:0] ZERO  = '0;
    localparam logic signed [EW-1:0] E_MAX = EW'(EXP_MAX);

    // ---------------- handshake ----------------
    logic s1_valid_q, s2_valid_q;
    logic s1_load, s2_load;

    assign s2_load   = !s2_valid_q || out_ready;
    assign s1_load   = !s1_valid_q || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;

    // ---------------- S1: normalize ----------------
    logic [SIG_W-1:0]     norm_sig;
    logic                 norm_inc;
    logic signed [EW-1:0] norm_exp;

    fp_div_norm #(
        .QW(QW),
        .EW(EW)
    ) u_norm (
        .quo_i    (in_quo),
        .sticky_i (in_sticky),
        .exp_i    (in_exp),
        .sig_o    (norm_sig),
        .inc_o    (norm_inc),
        .exp_o    (norm_exp)
    );

    logic                 s1_sign_q;
    logic [1:0]           s1_special_q;
    logic signed [EW-1:0] s1_exp_q;
    logic [SIG_W-1:0]     s1_sig_q;
    logic                 s1_inc_q;

    // ---------------- S2: round and pack ----------------
    logic [SIG_W:0]       sum;
    logic                 sum_hidden_unused;
    logic signed [EW-1:0] exp_fin;
    logic [FRAC_W-1:0]    mant;
    logic [31:0]          result_d;
    logic                 overflow_d;
    logic                 underflow_d;

    assign sum = {1'b0, s1_sig_q} + {{SIG_W{1'b0}}, s1_inc_q};
    // The hidden bit is implied by the packed format and not stored.
    assign sum_hidden_unused = sum[SIG_W-1];
    // A carry out of the significand means it rounded up to 2.0: renormalize.
    assign exp_fin = sum[SIG_W] ? s1_exp_q + ONE : s1_exp_q;
    assign mant    = sum[SIG_W] ? '0 : sum[FRAC_W-1:0];

    always_comb begin
        result_d    = {s1_sign_q, exp_fin[7:0], mant};
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        unique case (s1_special_q)
            CLS_ZERO: result_d = {s1_sign_q, 31'h0};
            CLS_INF:  result_d = {s1_sign_q, 8'hFF, 23'h0};
            CLS_NAN:  result_d = QNAN;
            default: begin
                if (exp_fin >= E_MAX) begin
                    result_d   = {s1_sign_q, 8'hFF, 23'h0};
                    overflow_d = 1'b1;
                end else if (exp_fin <= ZERO) begin
                    // Flush to zero: no denormals are produced.
                    result_d    = {s1_sign_q, 31'h0};
                    underflow_d = 1'b1;
                end
            end
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_special_q <= CLS_NORM;
            s1_exp_q     <= '0;
            s1_sig_q     <= '0;
            s1_inc_q     <= 1'b0;
        end else if (s1_load) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q    <= in_sign;
                s1_special_q <= in_special;
                s1_exp_q     <= norm_exp;
                s1_sig_q     <= norm_sig;
                s1_inc_q     <= norm_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s2_valid_q <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            // Bubbles leave the last result in place.
            if (s1_valid_q) begin
                result    <= result_d;
                overflow  <= overflow_d;
                underflow <= underflow_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_round.sv
// -----------------------------------------------------------------------------
// tb_fp_div_round
// Self-checking bench for fp_div_round: directed vector table with latency
// checks, hand-written backpressure and reset sequences, and a randomized
// stream scored against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fp_div_round;

    logic        clk;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [25:0] in_quo;
    logic        in_sticky;
    logic [1:0]  in_special;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    fp_div_round dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_quo     (in_quo),
        .in_sticky  (in_sticky),
        .in_special (in_special),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Reference model: value = quo / 2^25 * 2^(exp-127); keep 24 significant
    // bits, round the discarded part to nearest-even, then apply range limits.
    // Returns {overflow, underflow, result}.
    function automatic logic [33:0] model(input logic sign, input int exp_in,
                                          input logic [25:0] quo, input logic sticky,
                                          input logic [1:0] special);
        int shift, keep, rem, half, e;
        bit up;
        case (special)
            2'd1: return {2'b00, sign, 31'h0};
            2'd2: return {2'b00, sign, 8'hFF, 23'h0};
            2'd3: return {2'b00, 32'h7FC0_0000};
            default: ;
        endcase
        shift = (int'(quo) >= (1 << 25)) ? 2 : 1;
        keep  = int'(quo) >> shift;
        rem   = int'(quo) - (keep << shift);
        half  = 1 << (shift - 1);
        e     = exp_in + shift - 2;
        up    = (rem > half) || (rem == half && (sticky || (keep % 2 == 1)));
        keep  = keep + int'(up);
        if (keep == (1 << 24)) begin
            keep = 1 << 23;
            e    = e + 1;
        end
        if (e >= 255) return {2'b10, sign, 8'hFF, 23'h0};
        if (e <= 0)   return {2'b01, sign, 31'h0};
        return {2'b00, sign, e[7:0], keep[22:0]};
    endfunction

    // ---------------- streaming scoreboard ----------------
    logic [33:0] exp_q[$];
    logic [33:0] held_val;
    bit          held_v = 0;
    bit          in_fire = 0;
    bit          out_fire;
    int          n_out = 0;

    // Called just after a negedge with inputs set; advances one clock.
    task automatic step();
        #1;
        if (held_v)
            check("hold_stable", {out_valid, overflow, underflow, result}, {1'b1, held_val});
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        if (out_fire) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                check("stream_result", {overflow, underflow, result}, exp_q.pop_front());
                n_out++;
            end
        end
        held_v   = out_valid && !out_ready;
        held_val = {overflow, underflow, result};
        if (in_fire)
            exp_q.push_back(model(in_sign, int'($signed(in_exp)), in_quo, in_sticky, in_special));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_word(input logic s, input int e, input logic [25:0] q,
                            input logic st, input logic [1:0] sp);
        in_sign    = s;
        in_exp     = e[9:0];
        in_quo     = q;
        in_sticky  = st;
        in_special = sp;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        string       name;
        logic        sign;
        int          exp_v;
        logic [25:0] quo;
        logic        sticky;
        logic [1:0]  special;
        logic [31:0] res;
        logic        ov;
        logic        uf;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    task automatic apply_one(input vec_t v);
        set_word(v.sign, v.exp_v, v.quo, v.sticky, v.special);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check({v.name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({v.name, "_lat1"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1 check({v.name, "_valid"}, 64'(out_valid), 64'd1);
        check(v.name, {overflow, underflow, result}, {v.ov, v.uf, v.res});
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"unity_q25",     1'b0, 127, 26'h2000000, 1'b0, 2'd0, 32'h3F800000, 1'b0, 1'b0};
        vecs[1]  = '{"unity_q24",     1'b0, 128, 26'h1000000, 1'b0, 2'd0, 32'h3F800000, 1'b0, 1'b0};
        vecs[2]  = '{"tie_even_down", 1'b0, 127, 26'h2000002, 1'b0, 2'd0, 32'h3F800000, 1'b0, 1'b0};
        vecs[3]  = '{"tie_even_up",   1'b0, 127, 26'h2000006, 1'b0, 2'd0, 32'h3F800002, 1'b0, 1'b0};
        vecs[4]  = '{"tie_sticky",    1'b0, 127, 26'h2000002, 1'b1, 2'd0, 32'h3F800001, 1'b0, 1'b0};
        vecs[5]  = '{"round_carry",   1'b1, 127, 26'h3FFFFFE, 1'b0, 2'd0, 32'hC0000000, 1'b0, 1'b0};
        vecs[6]  = '{"overflow",      1'b0, 254, 26'h3FFFFFE, 1'b0, 2'd0, 32'h7F800000, 1'b1, 1'b0};
        vecs[7]  = '{"underflow",     1'b0, 1,   26'h1000000, 1'b0, 2'd0, 32'h00000000, 1'b0, 1'b1};
        vecs[8]  = '{"nan",           1'b1, 127, 26'h2000000, 1'b0, 2'd3, 32'h7FC00000, 1'b0, 1'b0};
        vecs[9]  = '{"inf_neg",       1'b1, 127, 26'h2000000, 1'b0, 2'd2, 32'hFF800000, 1'b0, 1'b0};
        vecs[10] = '{"zero_neg",      1'b1, 300, 26'h2000000, 1'b0, 2'd1, 32'h80000000, 1'b0, 1'b0};
        vecs[11] = '{"exp_254",       1'b0, 254, 26'h2000000, 1'b0, 2'd0, 32'h7F000000, 1'b0, 1'b0};
        vecs[12] = '{"exp_1",         1'b0, 1,   26'h2000000, 1'b0, 2'd0, 32'h00800000, 1'b0, 1'b0};
        vecs[13] = '{"exp_negative",  1'b1, -100, 26'h2000000, 1'b0, 2'd0, 32'h80000000, 1'b0, 1'b1};
        vecs[14] = '{"exp_255_q25",   1'b1, 255, 26'h2000000, 1'b0, 2'd0, 32'hFF800000, 1'b1, 1'b0};

        // ---------------- reset state ----------------
        n_rst     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_word(1'b0, 0, 26'h0, 1'b0, 2'd0);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result), 64'd0);
        check("rst_flags",     64'({overflow, underflow}), 64'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // ---------------- directed table ----------------
        for (int i = 0; i < NVEC; i++) apply_one(vecs[i]);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        n_out     = 0;
        held_v    = 0;
        set_word(1'b0, 127, 26'h2000000, 1'b0, 2'd0);
        in_valid = 1'b1;
        step();
        check("bp_accept0", 64'(in_fire), 64'd1);
        set_word(1'b0, 127, 26'h2000006, 1'b0, 2'd0);
        step();
        check("bp_accept1", 64'(in_fire), 64'd1);
        set_word(1'b1, 127, 26'h3FFFFFE, 1'b0, 2'd0);
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid",    64'(out_valid), 64'd1);
        check("bp_head_result",  64'(result), 64'h3F800000);
        step();
        check("bp_in_ready_low2", 64'(in_ready), 64'd0);
        step();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (exp_q.size() > 0 || in_valid); c++) begin
            step();
            if (in_fire) in_valid = 1'b0;
        end
        check("bp_out_count", 64'(n_out), 64'd3);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- randomized stream ----------------
        held_v  = 0;
        in_fire = 0;
        in_valid = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || in_fire) begin
                int e;
                logic [25:0] q;
                logic [1:0] sp;
                case ($urandom_range(0, 3))
                    0: e = int'($urandom_range(0, 763)) - 382;
                    1: e = int'($urandom_range(0, 4)) - 2;
                    2: e = int'($urandom_range(250, 258));
                    default: e = int'($urandom_range(100, 150));
                endcase
                q = 26'($urandom_range(32'h1000000, 32'h3FFFFFF));
                if ($urandom_range(0, 3) == 0) q[1:0] = 2'b10;
                if ($urandom_range(0, 15) == 0) q = 26'h3FFFFFE;
                sp = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
                set_word(1'($urandom_range(0, 1)), e, q, 1'($urandom_range(0, 1)), sp);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
        check("rand_drain_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        held_v    = 0;
        set_word(1'b0, 127, 26'h2000000, 1'b0, 2'd0);
        in_valid = 1'b1;
        step();
        set_word(1'b0, 130, 26'h1800000, 1'b0, 2'd0);
        step();
        in_valid = 1'b0;
        #1 check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #1 n_rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_outputs", 64'({overflow, underflow, result}), 64'd0);
        exp_q.delete();
        held_v = 0;
        @(negedge clk);
        #2 n_rst = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1 check("no_stale_out", 64'(out_valid), 64'd0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
